bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (1-cycle read latency) between NUM_REQ requesters, such as several AXI-lite BRAM controller front ends or a DMA engine.
- Each requester sees a request/response handshake with back-pressure.
- The block issues at most one BRAM access per cycle, chosen by round-robin.
- Each requester gets one response per accepted request (read data or write acknowledge), with read data held stable while stalled.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 64, BRAM word width; multiple of 8.
- ADDR_WIDTH, 12, BRAM word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted.
- req_we  in  NUM_REQ*DATA_WIDTH/8  byte write strobes, requester i at slice i; all-zero means read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  word address, sliced per requester.
- req_wrdata  in  NUM_REQ*DATA_WIDTH  write data, sliced per requester.
- resp_valid  out  NUM_REQ  response valid.
- resp_ready  in  NUM_REQ  response consumed.
- resp_rddata  out  NUM_REQ*DATA_WIDTH  read data; don't-care for write responses.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_WIDTH/8  BRAM byte write enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_wrdata  out  DATA_WIDTH  BRAM write data.
- bram_rddata  in  DATA_WIDTH  BRAM read data, valid exactly one cycle after the enabling cycle.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
- Eligibility:
  - Requester i is eligible when req_valid[i] && (!resp_valid[i] || resp_ready[i]).
  - So each requester has at most one outstanding response.
  - A new request may be accepted in the same cycle the previous response is consumed.
- Arbitration:
  - Round-robin among eligible requesters.
  - Search starts at pointer ptr and wraps modulo NUM_REQ.
  - On a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Grant outputs:
  - req_ready is one-hot or zero, and is combinational from req_valid, resp_valid, resp_ready and ptr.
  - Requesters must not make req_valid depend on req_ready.
- BRAM drive:
  - In the grant cycle: bram_en=1, bram_addr/bram_we/bram_wrdata = granted requester's slices.
  - With no grant: bram_en=0 and bram_we=0; addr and wrdata are don't-care.
- Response timing:
  - The cycle after a grant to i, resp_valid[i]=1 and resp_rddata slice i = bram_rddata (pass-through).
  - Latency from req fire to resp_valid is 1 cycle.
- Stall buffering:
  - If resp_valid[i] && !resp_ready[i] in the first response cycle, latch bram_rddata into a per-requester hold register.
  - resp_rddata then comes from the hold register until consumed.
  - Data must remain stable while stalled, even though other requesters use the BRAM.
- Response clear and overlap:
  - On resp_valid[i] && resp_ready[i] with no new grant to i, resp_valid[i] <= 0 and the latch flag clears.
  - A simultaneous new grant to i sets resp_valid[i] <= 1 (set wins) and returns to pass-through for the new data.
- Writes:
  - The response is an acknowledge only; resp_rddata is unspecified.
  - The hold register need not latch for writes; latching anyway is permitted.
- Reset:
  - resp_valid=0, latch flags=0, ptr=0 (requester 0 highest priority first).
  - An in-flight BRAM read whose reset lands between the enable and data cycles is discarded; no response is produced.
- Other cases:
  - Only one requester eligible: it is granted every cycle, giving full throughput (1 access/cycle) while responses are consumed immediately.

Decomposition:
- Sub-module openip_rr_arbiter:
  - Parameter N.
  - Inputs: request vector and advance strobe.
  - Outputs: one-hot grant and grant index.
  - Internal pointer register with synchronous active-high reset.
  - Reusable elsewhere.
- No shared package is needed. STRB_WIDTH = DATA_WIDTH/8 and IDX_WIDTH = $clog2(NUM_REQ), floored at 1, are localparams.
- Parameter check: $fatal if DATA_WIDTH % 8 != 0 or NUM_REQ < 2.

Test Plan:
- Contention fairness:
  - Stimulus: NUM_REQ=2, both issue continuous reads of 0x010/0x020, resp_ready=1.
  - Required: grants alternate 0,1,0,1; bram_en=1 every cycle; each resp_valid pulses every other cycle with correct data.
- Stalled response hold:
  - Stimulus: requester 0 reads 0x005 (memory 0xDEADBEEF) with resp_ready[0]=0 for 5 cycles, while requester 1 reads 0x006 every eligible cycle.
  - Required: resp_rddata[0] stays 0xDEADBEEF; requester 0 is not re-granted until consumed.
- Back-to-back turnaround:
  - Stimulus: requester 1 writes 0xA5 with strb 0x01 to 0x3FF, then immediately reads 0x3FF in the cycle its ack is consumed.
  - Required: read granted that same cycle; rddata low byte = 0xA5; other bytes unchanged.
- Pointer wrap:
  - Stimulus: NUM_REQ=3, only requesters 2 and 0 valid, ptr starting at 1.
  - Required: grant order 2,0,2,0.
- Reset mid-read:
  - Stimulus: assert rst in the cycle after a grant to requester 0.
  - Required: resp_valid=0 next cycle; ptr=0; no response ever appears for that read.
- Simultaneous consume and grant:
  - Stimulus: resp_valid[0] && resp_ready[0] together with a new grant to requester 0.
  - Required: resp_valid[0] stays 1; data switches to the new read's value without a bubble.

Source files
------------

// File: rtl/openip_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst       clock, synchronous active-high reset (pointer -> 0)
//   i_req[N]       request vector
//   i_advance      grant was taken this cycle; pointer moves past the winner
//   o_grant[N]     one-hot grant (zero when no request)
//   o_grant_idx    index of the granted requester (0 when no request)
module openip_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // (p + k) mod N for p < N and k <= N
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[wrap_add(r_ptr, k)]) begin
        w_found                    = 1'b1;
        w_idx                      = wrap_add(r_ptr, k);
        w_grant[wrap_add(r_ptr, k)] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= wrap_add(w_idx, 1);
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between NUM_REQ
// requesters, one access per cycle, round-robin.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready[NUM_REQ]  request handshake (ready is the grant)
//   req_we/req_addr/req_wrdata    per-requester slices; req_we == 0 is a read
//   resp_valid/resp_ready         response handshake, one per accepted request
//   resp_rddata                   per-requester read data, stable while stalled
//   bram_*                        BRAM port
module bram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wrdata,
  output logic [NUM_REQ-1:0]               resp_valid,
  input  logic [NUM_REQ-1:0]               resp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    resp_rddata,
  output logic                             bram_en,
  output logic [DATA_WIDTH/8-1:0]          bram_we,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_wrdata,
  input  logic [DATA_WIDTH-1:0]            bram_rddata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $fatal(1, "bram_port_arbiter: DATA_WIDTH must be a multiple of 8");
  end
  if (NUM_REQ < 2) begin : g_bad_num
    $fatal(1, "bram_port_arbiter: NUM_REQ must be at least 2");
  end

  logic [NUM_REQ-1:0]    r_resp_valid;
  logic [NUM_REQ-1:0]    r_latched;
  logic [DATA_WIDTH-1:0] r_hold [NUM_REQ];

  logic [NUM_REQ-1:0]    w_elig;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_WIDTH-1:0]  w_idx;
  logic                  w_bram_en;

  // Eligibility is masked during reset so no access is issued and no
  // response can be set up while the block is being cleared.
  assign w_elig = req_valid & (~r_resp_valid | resp_ready) & {NUM_REQ{~rst}};

  openip_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_elig),
    .i_advance   (w_bram_en),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx)
  );

  assign w_bram_en   = |w_grant;
  assign req_ready   = w_grant;
  assign bram_en     = w_bram_en;
  assign bram_we     = w_bram_en ? req_we[w_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
  assign bram_addr   = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign bram_wrdata = req_wrdata[w_idx*DATA_WIDTH +: DATA_WIDTH];

  // A read in flight when reset lands must never surface as a response.
  assign resp_valid = r_resp_valid & {NUM_REQ{~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= '0;
      r_latched    <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i]) begin
          // set wins over a simultaneous consume; new data is pass-through
          r_resp_valid[i] <= 1'b1;
          r_latched[i]    <= 1'b0;
        end else if (r_resp_valid[i] && resp_ready[i]) begin
          r_resp_valid[i] <= 1'b0;
          r_latched[i]    <= 1'b0;
        end else if (r_resp_valid[i] && !r_latched[i]) begin
          r_latched[i]    <= 1'b1;
        end
      end
    end
  end

  // Capture the BRAM output in the first stalled response cycle, before
  // another requester's access overwrites it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_resp_valid[i] && !r_latched[i] && !resp_ready[i]) begin
        r_hold[i] <= bram_rddata;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
    assign resp_rddata[g*DATA_WIDTH +: DATA_WIDTH] = r_latched[g] ? r_hold[g] : bram_rddata;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---- two-requester instance ----
  logic        a_rst;
  logic [1:0]  a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [7:0]  a_req_we;
  logic [23:0] a_req_addr;
  logic [63:0] a_req_wrdata, a_resp_rddata;
  logic        a_bram_en;
  logic [3:0]  a_bram_we;
  logic [11:0] a_bram_addr;
  logic [31:0] a_bram_wrdata, a_bram_rddata;
  logic [31:0] a_mem [4096];

  bram_port_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(12)) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wrdata(a_req_wrdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rddata(a_resp_rddata),
    .bram_en(a_bram_en), .bram_we(a_bram_we), .bram_addr(a_bram_addr),
    .bram_wrdata(a_bram_wrdata), .bram_rddata(a_bram_rddata)
  );

  always @(posedge clk) begin
    if (a_bram_en) begin
      a_bram_rddata <= a_mem[a_bram_addr];
      for (int b = 0; b < 4; b++)
        if (a_bram_we[b]) a_mem[a_bram_addr][b*8 +: 8] <= a_bram_wrdata[b*8 +: 8];
    end
  end

  // ---- three-requester instance ----
  logic        b_rst;
  logic [2:0]  b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [11:0] b_req_we;
  logic [35:0] b_req_addr;
  logic [95:0] b_req_wrdata, b_resp_rddata;
  logic        b_bram_en;
  logic [3:0]  b_bram_we;
  logic [11:0] b_bram_addr;
  logic [31:0] b_bram_wrdata, b_bram_rddata;

  bram_port_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(12)) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wrdata(b_req_wrdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rddata(b_resp_rddata),
    .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_addr(b_bram_addr),
    .bram_wrdata(b_bram_wrdata), .bram_rddata(b_bram_rddata)
  );

  always @(posedge clk) b_bram_rddata <= b_bram_en ? 32'h0000B0B0 : b_bram_rddata;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    next(); next();
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b00) begin n_errors++; $display("FAIL reset_resp_valid: got %b exp 00", a_resp_valid); end
    n_checks++;
    if (a_req_ready !== 2'b00) begin n_errors++; $display("FAIL reset_req_ready: got %b exp 00", a_req_ready); end
    n_checks++;
    if (a_bram_en !== 1'b0 || a_bram_we !== 4'h0) begin n_errors++; $display("FAIL reset_bram: en %b we %h exp 0 0", a_bram_en, a_bram_we); end
    n_checks++;
    if (b_resp_valid !== 3'b000) begin n_errors++; $display("FAIL reset_b_resp_valid: got %b exp 000", b_resp_valid); end
    next();
  endtask

  task automatic test_fairness();
    logic [1:0]  eg, prev;
    logic [11:0] ea;
    prev = 2'b00;
    a_req_valid = 2'b11; a_req_we = '0; a_req_addr = {12'h020, 12'h010}; a_resp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea = (k % 2 == 0) ? 12'h010 : 12'h020;
      n_checks++;
      if (a_req_ready !== eg || a_bram_en !== 1'b1 || a_bram_addr !== ea) begin
        n_errors++;
        $display("FAIL fair_grant[%0d]: ready %b en %b addr %h exp %b 1 %h", k, a_req_ready, a_bram_en, a_bram_addr, eg, ea);
      end
      if (k > 0) begin
        n_checks++;
        if (a_resp_valid !== prev) begin n_errors++; $display("FAIL fair_resp_valid[%0d]: got %b exp %b", k, a_resp_valid, prev); end
        n_checks++;
        if (prev == 2'b01 && a_resp_rddata[31:0] !== 32'h11110010) begin
          n_errors++; $display("FAIL fair_data0[%0d]: got %h exp 11110010", k, a_resp_rddata[31:0]);
        end else if (prev == 2'b10 && a_resp_rddata[63:32] !== 32'h22220020) begin
          n_errors++; $display("FAIL fair_data1[%0d]: got %h exp 22220020", k, a_resp_rddata[63:32]);
        end
      end
      prev = eg;
      next();
    end
    a_req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b10 || a_req_ready !== 2'b00 || a_bram_en !== 1'b0) begin
      n_errors++; $display("FAIL fair_tail: resp %b ready %b en %b exp 10 00 0", a_resp_valid, a_req_ready, a_bram_en);
    end
    next();
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b00) begin n_errors++; $display("FAIL fair_idle: got %b exp 00", a_resp_valid); end
    next();
  endtask

  // pointer is 0 on entry
  task automatic test_stall();
    a_req_valid = 2'b11; a_req_we = '0; a_req_addr = {12'h006, 12'h005}; a_resp_ready = 2'b10;
    @(negedge clk);
    n_checks++;
    if (a_req_ready !== 2'b01) begin n_errors++; $display("FAIL stall_first_grant: got %b exp 01", a_req_ready); end
    next();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (a_resp_valid[0] !== 1'b1 || a_resp_rddata[31:0] !== 32'hDEADBEEF) begin
        n_errors++; $display("FAIL stall_hold[%0d]: valid %b data %h exp 1 deadbeef", k, a_resp_valid[0], a_resp_rddata[31:0]);
      end
      n_checks++;
      if (a_req_ready !== 2'b10) begin n_errors++; $display("FAIL stall_grant[%0d]: got %b exp 10", k, a_req_ready); end
      next();
    end
    // consume requester 0 and issue a read of 0x006 in the same cycle
    a_resp_ready = 2'b11; a_req_addr = {12'h006, 12'h006};
    @(negedge clk);
    n_checks++;
    if (a_req_ready !== 2'b01 || a_resp_rddata[31:0] !== 32'hDEADBEEF) begin
      n_errors++; $display("FAIL stall_release: ready %b data %h exp 01 deadbeef", a_req_ready, a_resp_rddata[31:0]);
    end
    next();
    a_req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b01 || a_resp_rddata[31:0] !== 32'h66666666) begin
      n_errors++; $display("FAIL stall_passthru: valid %b data %h exp 01 66666666", a_resp_valid, a_resp_rddata[31:0]);
    end
    next();
  endtask

  // pointer is 1 on entry
  task automatic test_back_to_back();
    a_req_valid = 2'b10; a_req_we = {4'h1, 4'h0}; a_req_addr = {12'h3FF, 12'h000};
    a_req_wrdata = {32'hFFFFFFA5, 32'h0}; a_resp_ready = 2'b00;
    @(negedge clk);
    n_checks++;
    if (a_req_ready !== 2'b10 || a_bram_we !== 4'h1 || a_bram_addr !== 12'h3FF) begin
      n_errors++; $display("FAIL b2b_write: ready %b we %h addr %h exp 10 1 3ff", a_req_ready, a_bram_we, a_bram_addr);
    end
    next();
    a_req_we = '0; a_resp_ready = 2'b10;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b10 || a_req_ready !== 2'b10 || a_bram_we !== 4'h0) begin
      n_errors++; $display("FAIL b2b_turn: resp %b ready %b we %h exp 10 10 0", a_resp_valid, a_req_ready, a_bram_we);
    end
    next();
    a_req_valid = 2'b00; a_resp_ready = 2'b11;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b10 || a_resp_rddata[63:32] !== 32'h123456A5) begin
      n_errors++; $display("FAIL b2b_read: valid %b data %h exp 10 123456a5", a_resp_valid, a_resp_rddata[63:32]);
    end
    next();
  endtask

  // single eligible requester: granted every cycle, data follows without bubbles
  task automatic test_overlap();
    logic [11:0] addrs [4];
    logic [31:0] exps  [4];
    addrs[0] = 12'h010; addrs[1] = 12'h020; addrs[2] = 12'h005; addrs[3] = 12'h006;
    exps[0] = 32'h11110010; exps[1] = 32'h22220020; exps[2] = 32'hDEADBEEF; exps[3] = 32'h66666666;
    a_req_we = '0; a_resp_ready = 2'b11; a_req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) a_req_valid = 2'b00;
      else a_req_addr = {12'h000, addrs[k]};
      @(negedge clk);
      if (k < 4) begin
        n_checks++;
        if (a_req_ready !== 2'b01) begin n_errors++; $display("FAIL ovl_grant[%0d]: got %b exp 01", k, a_req_ready); end
      end
      if (k > 0) begin
        n_checks++;
        if (a_resp_valid[0] !== 1'b1 || a_resp_rddata[31:0] !== exps[k-1]) begin
          n_errors++; $display("FAIL ovl_data[%0d]: valid %b data %h exp 1 %h", k, a_resp_valid[0], a_resp_rddata[31:0], exps[k-1]);
        end
      end
      next();
    end
  endtask

  // pointer is 1 on entry; reset must bring it back to 0
  task automatic test_reset_mid_read();
    a_req_valid = 2'b01; a_req_we = '0; a_req_addr = {12'h020, 12'h010}; a_resp_ready = 2'b11;
    @(negedge clk);
    n_checks++;
    if (a_req_ready !== 2'b01) begin n_errors++; $display("FAIL rmr_grant: got %b exp 01", a_req_ready); end
    next();
    a_rst = 1'b1; a_req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b00) begin n_errors++; $display("FAIL rmr_during_reset: got %b exp 00", a_resp_valid); end
    next();
    a_rst = 1'b0; a_req_valid = 2'b11;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b00) begin n_errors++; $display("FAIL rmr_after_reset: got %b exp 00", a_resp_valid); end
    n_checks++;
    if (a_req_ready !== 2'b01) begin n_errors++; $display("FAIL rmr_ptr: got %b exp 01", a_req_ready); end
    next();
    a_req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (a_resp_valid !== 2'b01 || a_resp_rddata[31:0] !== 32'h11110010) begin
      n_errors++; $display("FAIL rmr_new_resp: valid %b data %h exp 01 11110010", a_resp_valid, a_resp_rddata[31:0]);
    end
    for (int k = 0; k < 2; k++) begin
      next();
      @(negedge clk);
      n_checks++;
      if (a_resp_valid !== 2'b00) begin n_errors++; $display("FAIL rmr_quiet[%0d]: got %b exp 00", k, a_resp_valid); end
    end
    next();
  endtask

  task automatic test_wrap();
    logic [2:0]  eg;
    logic [11:0] ea;
    b_req_we = '0; b_req_wrdata = '0; b_resp_ready = 3'b111;
    b_req_addr = {12'h020, 12'h0AA, 12'h010};
    b_req_valid = 3'b001;
    @(negedge clk);
    n_checks++;
    if (b_req_ready !== 3'b001) begin n_errors++; $display("FAIL wrap_setup: got %b exp 001", b_req_ready); end
    next();
    b_req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      eg = (k % 2 == 0) ? 3'b100 : 3'b001;
      ea = (k % 2 == 0) ? 12'h020 : 12'h010;
      n_checks++;
      if (b_req_ready !== eg || b_bram_addr !== ea) begin
        n_errors++; $display("FAIL wrap_order[%0d]: ready %b addr %h exp %b %h", k, b_req_ready, b_bram_addr, eg, ea);
      end
      next();
    end
    b_req_valid = 3'b000;
    next();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) a_mem[i] = 32'h0;
    a_mem[12'h010] = 32'h11110010;
    a_mem[12'h020] = 32'h22220020;
    a_mem[12'h005] = 32'hDEADBEEF;
    a_mem[12'h006] = 32'h66666666;
    a_mem[12'h3FF] = 32'h12345678;
    a_bram_rddata = '0;
    b_bram_rddata = '0;
  end

  initial begin
    a_req_valid = '0; a_req_we = '0; a_req_addr = '0; a_req_wrdata = '0; a_resp_ready = '0;
    b_req_valid = '0; b_req_we = '0; b_req_addr = '0; b_req_wrdata = '0; b_resp_ready = '0;
    a_rst = 1'b1; b_rst = 1'b1;
    #1;
    test_reset();
    test_fairness();
    test_stall();
    test_back_to_back();
    test_overlap();
    test_reset_mid_read();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
